// File: rtl/psa_disp_pkg.sv
// Shared display-path definitions: widths, saturation value, converter states and
// the blank mask that matches an all-zero display.
package psa_disp_pkg;

    localparam int unsigned BIN_W       = 16;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned ACC_NIBBLES = BCD_DIGITS + 1;
    localparam int unsigned SAT_VAL     = 9999;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } conv_state_e;

    localparam logic [3:0] BLANK_RST = 4'b1110;

    // Decimal digit 'pos' (0 = units) of a constant, used to build the saturation pattern.
    function automatic logic [3:0] sat_digit(input int unsigned val, input int unsigned pos);
        int unsigned v;
        v = val;
        for (int i = 0; i < int'(pos); i++) begin
            v = v / 10;
        end
        return 4'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit that would overflow on the next shift.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/found_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter with a latest-wins request buffer,
// saturation to four digits and leading-zero blank flags.
module found_bcd_conv #(
    parameter int unsigned BIN_W   = psa_disp_pkg::BIN_W,
    parameter int unsigned SAT_VAL = psa_disp_pkg::SAT_VAL
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             busy,
    output logic             bcd_valid,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic             overflow,
    output logic [3:0]       blank
);

    import psa_disp_pkg::*;

    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam int unsigned ACC_W = 4 * ACC_NIBBLES;

    localparam logic [15:0] SAT_DIGITS = {sat_digit(SAT_VAL, 3), sat_digit(SAT_VAL, 2),
                                          sat_digit(SAT_VAL, 1), sat_digit(SAT_VAL, 0)};

    conv_state_e      state_q;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] pend_val_q;
    logic             pend_v_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_adj;
    logic [CNT_W-1:0] count_q;

    logic [15:0]      dig_q;
    logic             overflow_q;
    logic [3:0]       blank_q;
    logic             bcd_valid_q;
    logic             busy_q;

    logic             ovf_d;
    logic [15:0]      dig_d;
    logic [3:0]       blank_d;

    for (genvar g = 0; g < int'(ACC_NIBBLES); g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (acc_q[4*g +: 4]),
            .nib_o (acc_adj[4*g +: 4])
        );
    end

    // A non-zero ten-thousands nibble means the value does not fit the display.
    always_comb begin
        ovf_d      = |acc_q[ACC_W-1 -: 4];
        dig_d      = ovf_d ? SAT_DIGITS : acc_q[15:0];
        blank_d    = 4'b0000;
        blank_d[3] = (dig_d[15:12] == 4'd0);
        blank_d[2] = blank_d[3] & (dig_d[11:8] == 4'd0);
        blank_d[1] = blank_d[2] & (dig_d[7:4] == 4'd0);
    end

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            pend_val_q  <= '0;
            pend_v_q    <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            dig_q       <= '0;
            overflow_q  <= 1'b0;
            blank_q     <= BLANK_RST;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bin_valid) begin
                        bin_q   <= bin_in;
                        acc_q   <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
                    count_q        <= count_q + CNT_W'(1);
                    if (count_q == CNT_W'(BIN_W - 1)) begin
                        state_q <= StDone;
                    end
                    if (bin_valid) begin
                        pend_val_q <= bin_in;
                        pend_v_q   <= 1'b1;
                    end
                end
                StDone: begin
                    dig_q       <= dig_d;
                    overflow_q  <= ovf_d;
                    blank_q     <= blank_d;
                    bcd_valid_q <= 1'b1;
                    acc_q       <= '0;
                    count_q     <= '0;
                    // A fresh request beats the buffered one; either way the buffer empties.
                    if (bin_valid) begin
                        bin_q    <= bin_in;
                        pend_v_q <= 1'b0;
                        state_q  <= StShift;
                    end else if (pend_v_q) begin
                        bin_q    <= pend_val_q;
                        pend_v_q <= 1'b0;
                        state_q  <= StShift;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign bcd_valid = bcd_valid_q;
    assign thousands = dig_q[15:12];
    assign hundreds  = dig_q[11:8];
    assign tens      = dig_q[7:4];
    assign units     = dig_q[3:0];
    assign overflow  = overflow_q;
    assign blank     = blank_q;

endmodule

// File: tb/tb_found_bcd_conv.sv
// Scoreboard bench for found_bcd_conv: an arithmetic model queues expected digits per
// request and a monitor compares them on every bcd_valid pulse.
module tb_found_bcd_conv;

    logic        clk;
    logic        reset;
    logic [15:0] bin_in;
    logic        bin_valid;
    logic        busy;
    logic        bcd_valid;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        overflow;
    logic [3:0]  blank;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pulses = 0;
    logic [20:0] exp_q[$];

    found_bcd_conv #(
        .BIN_W   (16),
        .SAT_VAL (9999)
    ) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .units     (units),
        .overflow  (overflow),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Packed {thousands, hundreds, tens, units, overflow, blank}.
    function automatic logic [20:0] model(input int v);
        int         s;
        logic [3:0] th, hu, te, un;
        logic [3:0] bl;
        logic       ov;
        ov = (v > 9999);
        s  = ov ? 9999 : v;
        th = 4'(s / 1000);
        hu = 4'((s / 100) % 10);
        te = 4'((s / 10) % 10);
        un = 4'(s % 10);
        bl    = 4'b0000;
        bl[3] = (th == 0);
        bl[2] = bl[3] && (hu == 0);
        bl[1] = bl[2] && (te == 0);
        return {th, hu, te, un, ov, bl};
    endfunction

    function automatic logic [31:0] observed();
        return 32'({thousands, hundreds, tens, units, overflow, blank});
    endfunction

    always @(negedge clk) begin
        if (reset && bcd_valid) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_bcd_valid", observed(), 32'h1fffff);
            end else begin
                check("digits", observed(), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input int v, input bit push);
        @(negedge clk);
        bin_in    = 16'(v);
        bin_valid = 1'b1;
        if (push) exp_q.push_back(model(v));
        @(posedge clk);
        #1 bin_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        bit seen;
        start = n_pulses;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (n_pulses != start);
        end
        if (!seen) check("timeout_bcd_valid", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic convert(input int v);
        drive(v, 1'b1);
        wait_done();
    endtask

    initial begin
        int p0;
        reset     = 1'b0;
        bin_in    = '0;
        bin_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", observed(), 32'(model(0)));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(bcd_valid), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_digits", observed(), 32'(model(0)));
        check("idle_pulses", 32'(n_pulses), 32'd0);

        // Latency: busy after edges N..N+16, valid and idle after N+17.
        drive(1234, 1'b1);
        for (int i = 0; i < 17; i++) begin
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_no_valid", 32'(bcd_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("lat_valid", 32'(bcd_valid), 32'd1);
        check("lat_busy_fall", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("valid_one_cycle", 32'(bcd_valid), 32'd0);
        check("hold_digits", observed(), 32'(model(1234)));

        convert(7);
        convert(40);
        convert(0);
        convert(9999);
        convert(10000);
        convert(65535);
        convert(10);
        convert(305);

        // Back-to-back: 555 is overwritten by 999 while 100 is converting.
        p0 = n_pulses;
        drive(100, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            bin_valid = (k == 5) || (k == 9);
            bin_in    = (k == 5) ? 16'd555 : 16'd999;
            if (k == 9) exp_q.push_back(model(999));
            @(posedge clk);
            #1 bin_valid = 1'b0;
            check("chain_busy", 32'(busy), (k < 34) ? 32'd1 : 32'd0);
        end
        repeat (5) @(negedge clk);
        check("chain_pulses", 32'(n_pulses - p0), 32'd2);
        check("chain_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-conversion discards the request.
        drive(4321, 1'b1);
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_digits", observed(), 32'(model(0)));
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(bcd_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        p0 = n_pulses;
        repeat (40) @(negedge clk);
        check("post_rst_no_valid", 32'(n_pulses - p0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        convert(58);
        check("post_rst_58", observed(), 32'(model(58)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/found_bcd_conv.md
# found_bcd_conv

Sequential binary-to-BCD converter that sits between the `search` block's 16-bit `found` address and the `SS_Driver` seven-segment stage. It replaces the combinational divide/modulo digit split with a 16-iteration shift-and-add-3 (double-dabble) engine. It holds the last converted result on four registered digit outputs and provides a one-deep latest-wins input buffer, saturation at 9999 and leading-zero blanking flags.

## Interface
Parameters:
- `BIN_W`, 16: width of the binary input. Iteration count equals `BIN_W`.
- `SAT_VAL`, 9999: value displayed when the input exceeds four decimal digits.

Ports:
- `CLK100MHZ`  in  1  system clock, 100 MHz, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `bin_in`  in  16  binary value to convert, sampled only when `bin_valid` = 1.
- `bin_valid`  in  1  one-cycle request strobe.
- `busy`  out  1  high whenever state ≠ IDLE.
- `bcd_valid`  out  1  one-cycle pulse when new digits are latched.
- `thousands`, `hundreds`, `tens`, `units`  out  4 each  registered BCD digits.
- `overflow`  out  1  set when the last result was saturated.
- `blank`  out  4  leading-zero mask; bit 3 = thousands … bit 0 = units.

## Operation
- States are IDLE, SHIFT and DONE.
- **IDLE**: when `bin_valid` = 1, load `bin_in` into the shift register, clear the 20-bit BCD accumulator (5 nibbles), set count = 0, go to SHIFT.
- **SHIFT**: each cycle performs one iteration.
  - Every nibble ≥ 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - count increments; after iteration 16, go to DONE.
- **SHIFT input buffering**: `bin_valid` writes the pending buffer and sets `pend_v`. A newer request overwrites an older pending one.
- **DONE**:
  - Latch the digits and pulse `bcd_valid`.
  - If nibble 4 (ten-thousands) ≠ 0, output 9,9,9,9 and set `overflow` = 1; otherwise copy nibbles 3..0 and set `overflow` = 0.
  - Next state, in priority order:
    1. `bin_valid` this cycle: load `bin_in` directly, clear `pend_v`, go to SHIFT.
    2. Else `pend_v` set: load the pending value, clear `pend_v`, go to SHIFT.
    3. Else go to IDLE.
- **blank** is registered together with the digits:
  - blank[3] = (thousands == 0)
  - blank[2] = blank[3] & (hundreds == 0)
  - blank[1] = blank[2] & (tens == 0)
  - blank[0] = 0 always.
- Digits, `overflow` and `blank` hold their values between conversions.
- **Reset** (asynchronous, any state):
  - state = IDLE, `pend_v` = 0, accumulator = 0, count = 0.
  - Outputs: digits = 0, `overflow` = 0, `blank` = 4'b1110, `bcd_valid` = 0, `busy` = 0.
  - An in-flight conversion is discarded and produces no `bcd_valid` after release.

## Timing
- Request sampled at edge N in IDLE → `busy` = 1 after edge N.
- Iterations run on edges N+1..N+16; state = DONE after N+16.
- Digits update and `bcd_valid` = 1 after edge N+17, for exactly one cycle.
- Latency is 17 cycles, fixed for every input including saturated values.
- Throughput is one conversion per 17 cycles when requests are back-to-back.
- `busy` stays high across DONE→SHIFT chaining and drops only on entry to IDLE.
- `busy` falls in the same cycle that `bcd_valid` is high if nothing is queued.
- Outputs are registered only; no combinational path from `bin_in` to any output.

## Structure
- Shared package/include `psa_disp_pkg`: `BIN_W`, `BCD_DIGITS` = 4, `SAT_VAL`, state encodings (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2), blank reset constant 4'b1110.
- Sub-module `bcd_add3`: combinational 4-bit correction (in ≥ 5 ? in + 3 : in), instantiated 5× in the iteration datapath.
- `top` instantiates `found_bcd_conv`:
  - `bin_in` is driven from `search.found`.
  - `bin_valid` is a change-detect pulse on `found`.
  - The digits feed `SS_Driver`.

## Test plan
- Hold `reset` = 0 → digits 0/0/0/0, `blank` = 1110, `busy` = 0, `bcd_valid` = 0; release, idle 20 cycles → no change.
- `bin_in` = 1234 pulsed at edge N → `bcd_valid` only after N+17; digits 1,2,3,4; `overflow` = 0; `blank` = 0000; `busy` high N+1..N+17.
- `bin_in` = 7 → 0,0,0,7, `blank` = 1110; then 40 → 0,0,4,0, `blank` = 1100; then 0 → `blank` = 1110.
- Saturation boundary:
  - `bin_in` = 9999 → 9,9,9,9, `overflow` = 0.
  - `bin_in` = 10000 → 9,9,9,9, `overflow` = 1.
  - `bin_in` = 65535 → 9,9,9,9, `overflow` = 1.
- Requests 100 at N, 555 at N+5, 999 at N+9:
  - 100 appears after N+17; 999 appears after N+34.
  - 555 never appears.
  - Exactly two `bcd_valid` pulses; `busy` stays continuously high N+1..N+34.
- Request 4321 at N, drive `reset` = 0 at N+8 for 2 cycles → outputs return to reset values immediately; no `bcd_valid` within 40 cycles after release; a fresh request for 58 then completes normally as 0,0,5,8.
